// File: rtl/mc_fetch_unit.sv
// Multi-cycle instruction fetch stage: holds the PC, reads the inst SRAM and
// hands one {inst, pc} bundle at a time to decode over a valid/allowin handshake.
module mc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h1c000000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic             inst_sram_en,
    output logic             inst_sram_we,
    output logic [31:0]      inst_sram_addr,
    output logic [31:0]      inst_sram_wdata,
    input  logic [31:0]      inst_sram_rdata,
    output logic             fs_to_ds_valid,
    output logic [31:0]      fs_to_ds_inst,
    output logic [31:0]      fs_to_ds_pc,
    output logic             fs_to_ds_adef,
    input  logic             ds_allowin,
    input  logic             pc_upd_valid,
    input  logic [31:0]      pc_upd_value,
    output logic [CNT_W-1:0] fetch_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_VALID,
        S_WAIT_PC
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        ir_q, ir_d;
    logic               adef_q, adef_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               en_q, en_d;
    logic [31:0]        addr_q, addr_d;
    logic               valid_q, valid_d;

    // Next state; en/valid/addr are derived from the next state so they line up with it.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        adef_d  = adef_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE:  state_d = S_REQ;
            S_REQ: begin
                if (pc_q[1:0] == 2'b00) begin
                    state_d = S_WAIT;
                end else begin
                    adef_d  = 1'b1;
                    ir_d    = 32'h0;
                    state_d = S_VALID;
                end
            end
            S_WAIT: begin
                ir_d    = inst_sram_rdata;
                adef_d  = 1'b0;
                state_d = S_VALID;
            end
            S_VALID: begin
                if (ds_allowin) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_WAIT_PC;
                end
            end
            S_WAIT_PC: begin
                if (pc_upd_valid) begin
                    pc_d    = pc_upd_value;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
        en_d    = (state_d == S_REQ) && (pc_d[1:0] == 2'b00);
        if (en_d) begin
            addr_d = {pc_d[31:2], 2'b00};
        end
        valid_d = (state_d == S_VALID);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= 32'h0;
            adef_q  <= 1'b0;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            addr_q  <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            adef_q  <= adef_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
        end
    end

    assign inst_sram_en    = en_q;
    assign inst_sram_we    = 1'b0;
    assign inst_sram_addr  = addr_q;
    assign inst_sram_wdata = 32'h0;
    assign fs_to_ds_valid  = valid_q;
    assign fs_to_ds_inst   = ir_q;
    assign fs_to_ds_pc     = pc_q;
    assign fs_to_ds_adef   = adef_q;
    assign fetch_cnt       = cnt_q;

endmodule

// File: tb/tb_mc_fetch_unit.sv
// Scoreboard bench for mc_fetch_unit: stimulus queues expected SRAM addresses and
// bundles, a negedge monitor pops and compares whatever the DUT presents.
module tb_mc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_sram_en;
    logic        inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata = 32'hdeadbeef;
    logic        fs_to_ds_valid;
    logic [31:0] fs_to_ds_inst;
    logic [31:0] fs_to_ds_pc;
    logic        fs_to_ds_adef;
    logic        ds_allowin = 1'b0;
    logic        pc_upd_valid = 1'b0;
    logic [31:0] pc_upd_value = 32'h0;
    logic [3:0]  fetch_cnt;

    mc_fetch_unit #(.RESET_PC(32'h1c000000), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .inst_sram_en(inst_sram_en), .inst_sram_we(inst_sram_we),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_rdata(inst_sram_rdata),
        .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_inst(fs_to_ds_inst),
        .fs_to_ds_pc(fs_to_ds_pc), .fs_to_ds_adef(fs_to_ds_adef),
        .ds_allowin(ds_allowin), .pc_upd_valid(pc_upd_valid),
        .pc_upd_value(pc_upd_value), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        adef;
        logic [3:0]  cnt;
    } bundle_t;

    bundle_t     exp_q[$];
    logic [31:0] addr_q[$];

    int          checks = 0;
    int          errors = 0;
    logic [3:0]  model_cnt = 4'd0;
    logic        probe_rst = 1'b0;
    logic        probe_cnt_en = 1'b0;
    logic [3:0]  probe_cnt_val = 4'd0;
    logic        probe_en_chk = 1'b0;
    logic        probe_en_val = 1'b0;
    logic        probe_valid = 1'b0;
    logic        done = 1'b0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'h1e800421;
    endfunction

    // SRAM model with one-cycle read latency; rdata holds its last value otherwise.
    always @(posedge clk) begin
        if (inst_sram_en) inst_sram_rdata <= word_at(inst_sram_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    int      cyc = 0;
    int      en_cyc = 0;
    logic    valid_prev = 1'b0;
    bundle_t mb;

    always @(negedge clk) begin
        cyc++;
        if (probe_rst) begin
            chk("rst_valid", 32'(fs_to_ds_valid), 32'd0);
            chk("rst_en", 32'(inst_sram_en), 32'd0);
            chk("rst_addr", inst_sram_addr, 32'h0);
            chk("rst_inst", fs_to_ds_inst, 32'h0);
            chk("rst_pc", fs_to_ds_pc, 32'h1c000000);
            chk("rst_adef", 32'(fs_to_ds_adef), 32'd0);
            chk("rst_cnt", 32'(fetch_cnt), 32'd0);
        end
        chk("sram_we", 32'(inst_sram_we), 32'd0);
        chk("sram_wdata", inst_sram_wdata, 32'h0);
        if (probe_en_chk) chk("upd_to_en", 32'(inst_sram_en), 32'(probe_en_val));
        if (probe_valid) chk("misalign_latency", 32'(fs_to_ds_valid), 32'd1);
        if (probe_cnt_en) chk("fetch_cnt", 32'(fetch_cnt), 32'(probe_cnt_val));
        if (inst_sram_en) begin
            if (addr_q.size() == 0) begin
                chk("unexpected_en", inst_sram_addr, 32'hffffffff);
            end else begin
                chk("sram_addr", inst_sram_addr, addr_q.pop_front());
            end
            en_cyc = cyc;
        end
        if (fs_to_ds_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", fs_to_ds_pc, 32'hffffffff);
            end else begin
                mb = exp_q[0];
                if (!valid_prev && !mb.adef) chk("read_latency", 32'(cyc - en_cyc), 32'd2);
                chk("bundle_inst", fs_to_ds_inst, mb.inst);
                chk("bundle_pc", fs_to_ds_pc, mb.pc);
                chk("bundle_adef", 32'(fs_to_ds_adef), 32'(mb.adef));
                if (ds_allowin) begin
                    chk("cnt_at_accept", 32'(fetch_cnt), 32'(mb.cnt));
                    void'(exp_q.pop_front());
                end
            end
        end
        valid_prev = fs_to_ds_valid;
        if (done) begin
            chk("bundles_drained", 32'(exp_q.size()), 32'd0);
            chk("addrs_drained", 32'(addr_q.size()), 32'd0);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        probe_rst    = 1'b0;
        probe_cnt_en = 1'b0;
        probe_en_chk = 1'b0;
        probe_valid  = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        exp_q.delete();
        addr_q.delete();
        model_cnt = 4'd0;
        for (int i = 0; i < n; i++) begin
            step();
            probe_rst = 1'b1;
        end
        addr_q.push_back(32'h1c000000);
        reset = 1'b0;
        step();
        probe_en_chk = 1'b1;
        probe_en_val = 1'b1;
    endtask

    task automatic redirect(input logic [31:0] v, input logic aligned);
        if (aligned) addr_q.push_back(v);
        pc_upd_valid = 1'b1;
        pc_upd_value = v;
        step();
        pc_upd_valid = 1'b0;
        probe_en_chk = 1'b1;
        probe_en_val = aligned;
    endtask

    task automatic do_bundle(input logic [31:0] inst, input logic [31:0] pc,
                             input logic adef, input int stall, input logic pulse);
        bundle_t b;
        int      n;
        b.inst = inst; b.pc = pc; b.adef = adef; b.cnt = model_cnt;
        exp_q.push_back(b);
        if (adef) begin
            step();
            probe_valid = 1'b1;
        end
        n = 0;
        while (!fs_to_ds_valid) begin
            if (n == 20) begin
                $display("FAIL valid_timeout: got no valid expected valid for pc 0x%08h", pc);
                $fatal(1, "valid timeout");
            end
            step();
            n++;
        end
        for (int s = 0; s < stall; s++) begin
            if (pulse && s == 1) begin
                pc_upd_valid = 1'b1;
                pc_upd_value = 32'h1c0000f0;
            end
            step();
            pc_upd_valid = 1'b0;
        end
        ds_allowin = 1'b1;
        if (pulse) begin
            pc_upd_valid = 1'b1;
            pc_upd_value = 32'h1c0000f0;
        end
        step();
        ds_allowin   = 1'b0;
        pc_upd_valid = 1'b0;
        model_cnt    = model_cnt + 4'd1;
        probe_cnt_val = model_cnt;
        probe_cnt_en  = 1'b1;
    endtask

    initial begin
        do_reset(3);
        do_bundle(32'h02800421, 32'h1c000000, 1'b0, 3, 1'b0);
        redirect(32'h1c000010, 1'b1);
        do_bundle(32'h02800431, 32'h1c000010, 1'b0, 3, 1'b1);
        redirect(32'h1c000002, 1'b0);
        do_bundle(32'h00000000, 32'h1c000002, 1'b1, 1, 1'b0);
        redirect(32'h1c000004, 1'b1);
        step();
        do_reset(2);
        do_bundle(32'h02800421, 32'h1c000000, 1'b0, 0, 1'b0);
        for (int i = 1; i < 16; i++) begin
            redirect(32'h1c000000 + 32'(4 * i), 1'b1);
            do_bundle(word_at(32'h1c000000 + 32'(4 * i)), 32'h1c000000 + 32'(4 * i), 1'b0, 0, 1'b0);
        end
        step();
        step();
        done = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "global timeout");
    end

endmodule
